// File: rtl/tx_pkg.sv
// Shared definitions for the TX frame reader: default widths, the maximum
// frame length and the FSM state encoding. The CSUM state only exists when
// TX_FRAME_CSUM_EN is defined.
package tx_pkg;

  localparam int TX_ADDR_W = 11;    // 2048 x 8 sample buffer
  localparam int TX_LEN_W  = 12;    // holds 1..2048
  localparam int MAX_LEN   = 2048;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
`ifdef TX_FRAME_CSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_DONE  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/tx_skid_fifo.sv
// Two-entry FIFO holding buffer bytes plus a "final payload byte" flag,
// sitting between the buffer read port and the output stream. The writer
// guarantees it never pushes into a full FIFO unless a pop happens in the
// same cycle; the guards below only keep the pointers consistent.
module tx_skid_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_last_i,
  input  logic       rd_en_i,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  output logic       rd_last_o,
  output logic [1:0] count_o
);

  logic [7:0] data_q [0:1];
  logic       last_q [0:1];
  logic       wptr_q;
  logic       rptr_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       wr_s;
  logic       rd_s;

  // Qualify push/pop against occupancy and compute the next count.
  always_comb begin
    rd_s  = rd_en_i && (cnt_q != 2'd0);
    wr_s  = wr_en_i && ((cnt_q != 2'd2) || rd_s);
    cnt_d = cnt_q + {1'b0, wr_s} - {1'b0, rd_s};
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= 8'd0;
      data_q[1] <= 8'd0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (wr_s) begin
        data_q[wptr_q] <= wr_data_i;
        last_q[wptr_q] <= wr_last_i;
        wptr_q         <= ~wptr_q;
      end
      if (rd_s) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign rd_valid_o = (cnt_q != 2'd0);
  assign rd_data_o  = data_q[rptr_q];
  assign rd_last_o  = last_q[rptr_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/tx_frame_reader.sv
// Reads a frame of bytes out of the 2048 x 8 sample buffer (bypass-mode
// read port, one cycle from sampled address to data) and streams it to the
// TX serializer over a valid/ready byte interface.
// Optional feature: define TX_FRAME_CSUM_EN to append a mod-256 checksum
// byte after the payload; the checksum byte then carries m_tlast.
module tx_frame_reader
  import tx_pkg::*;
#(
  parameter int ADDR_W = TX_ADDR_W,
  parameter int LEN_W  = TX_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_adb,
  output logic              ram_ceb,
  output logic              ram_oce,
  input  logic [7:0]        ram_dout,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] adb_q, adb_d;
  logic [LEN_W-1:0]  rem_q, rem_d;      // reads still to be issued
  logic              rv_q;              // read data on ram_dout this cycle
  logic              rv_last_q;         // ...and it is the final payload byte
  logic              ceb_s;
  logic              pop_s;
  logic              space_s;
  logic              len_ok_s;
  logic [2:0]        occ_s;
  logic              fifo_valid_s;
  logic              fifo_last_s;
  logic [7:0]        fifo_data_s;
  logic [1:0]        fifo_cnt_s;
`ifdef TX_FRAME_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  tx_skid_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (rv_q),
    .wr_data_i  (ram_dout),
    .wr_last_i  (rv_last_q),
    .rd_en_i    (pop_s),
    .rd_valid_o (fifo_valid_s),
    .rd_data_o  (fifo_data_s),
    .rd_last_o  (fifo_last_s),
    .count_o    (fifo_cnt_s)
  );

  // Slot accounting: FIFO entries plus the read whose data is on ram_dout,
  // less the byte leaving this cycle. A new read lands two edges from now,
  // so it may be issued only if that total leaves a slot free.
  always_comb begin
    pop_s    = fifo_valid_s && m_tready;
    occ_s    = {1'b0, fifo_cnt_s} + {2'b00, rv_q} - {2'b00, pop_s};
    space_s  = (occ_s < 3'd2);
    len_ok_s = (length != {LEN_W{1'b0}}) && (length <= LEN_W'(MAX_LEN));
  end

  // Next-state logic, read issue and checksum accumulation.
  always_comb begin
    state_d = state_q;
    adb_d   = adb_q;
    rem_d   = rem_q;
    ceb_s   = 1'b0;
`ifdef TX_FRAME_CSUM_EN
    if (pop_s) begin
      csum_d = csum_q + fifo_data_s;
    end else begin
      csum_d = csum_q;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && len_ok_s) begin
          state_d = ST_READ;
          adb_d   = start_addr;
          rem_d   = length;
`ifdef TX_FRAME_CSUM_EN
          csum_d  = 8'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (space_s) begin
          ceb_s = 1'b1;
          adb_d = adb_q + ADDR_W'(1);   // natural wrap 2047 -> 0
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (pop_s && fifo_last_s) begin
`ifdef TX_FRAME_CSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_DRAIN;
        end
      end
`ifdef TX_FRAME_CSUM_EN
      ST_CSUM: begin
        if (m_tready) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, address, remaining count and read-pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      adb_q     <= {ADDR_W{1'b0}};
      rem_q     <= {LEN_W{1'b0}};
      rv_q      <= 1'b0;
      rv_last_q <= 1'b0;
`ifdef TX_FRAME_CSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      adb_q     <= adb_d;
      rem_q     <= rem_d;
      rv_q      <= ceb_s;
      rv_last_q <= ceb_s && (rem_q == LEN_W'(1));
`ifdef TX_FRAME_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign ram_adb = adb_q;
  assign ram_ceb = ceb_s;
  assign ram_oce = 1'b1;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

`ifdef TX_FRAME_CSUM_EN
  assign m_tvalid = fifo_valid_s || (state_q == ST_CSUM);
  assign m_tdata  = (state_q == ST_CSUM) ? csum_q : fifo_data_s;
  assign m_tlast  = (state_q == ST_CSUM);
`else
  assign m_tvalid = fifo_valid_s;
  assign m_tdata  = fifo_data_s;
  assign m_tlast  = fifo_valid_s && fifo_last_s;
`endif

endmodule

// File: tb/tb_tx_frame_reader.sv
// Self-checking bench for tx_frame_reader: a behavioural bypass-mode buffer,
// a scoreboard of expected {last,data} bytes filled from the buffer contents,
// and one task per scenario.
module tb_tx_frame_reader;
  import tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] start_addr = 11'd0;
  logic [11:0] length = 12'd0;
  logic        busy, done, ram_ceb, ram_oce, m_tvalid, m_tlast;
  logic [10:0] ram_adb;
  logic [7:0]  ram_dout = 8'h00;
  logic [7:0]  m_tdata;
  logic        m_tready = 1'b1;

  logic [7:0]  mem [0:2047];
  logic [8:0]  exp_q [$];
  logic [10:0] adb_log [$];
  int checks = 0;
  int errors = 0;
  int first_cyc, last_cyc, nbytes;
  logic aborted;

  tx_frame_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .ram_adb(ram_adb), .ram_ceb(ram_ceb), .ram_oce(ram_oce),
    .ram_dout(ram_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_ceb) ram_dout <= mem[ram_adb];

`ifdef TX_FRAME_CSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  task automatic expect_frame(input logic [10:0] addr, input int len);
    logic [10:0] a;
`ifdef TX_FRAME_CSUM_EN
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 0; i < len; i++) begin
      a = addr + 11'(i);
      sum = sum + mem[a];
      exp_q.push_back({1'b0, mem[a]});
    end
    exp_q.push_back({1'b1, sum});
`else
    for (int i = 0; i < len; i++) begin
      a = addr + 11'(i);
      exp_q.push_back({(i == len - 1), mem[a]});
    end
`endif
  endtask

  task automatic start_frame(input logic [10:0] addr, input logic [11:0] len);
    @(posedge clk); #1;
    start = 1'b1; start_addr = addr; length = len;
    adb_log.delete();
  endtask

  // mode 0: ready held high; mode 1: ready toggles. Stops on done, abort or budget.
  task automatic collect(input int mode, input int max_cycles, input int abort_after,
                         input int restart_at);
    int cyc;
    logic got_done, held, prev_last, hl;
    logic [7:0] hd;
    logic [8:0] e;
    cyc = 0; got_done = 1'b0; held = 1'b0; prev_last = 1'b0; hl = 1'b0; hd = 8'd0;
    first_cyc = -1; last_cyc = -1; nbytes = 0; aborted = 1'b0;
    while (!got_done && !aborted && cyc < max_cycles) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == restart_at) begin
        start = 1'b1; start_addr = 11'h300; length = 12'd3;
      end
      m_tready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      @(negedge clk);
      cyc++;
      if (ram_ceb) adb_log.push_back(ram_adb);
      if (held) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== hd || m_tlast !== hl) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%02h l=%0b, want v=1 d=%02h l=%0b",
                   m_tvalid, m_tdata, m_tlast, hd, hl);
        end
      end
      held = m_tvalid && !m_tready; hd = m_tdata; hl = m_tlast;
      if (done) begin
        got_done = 1'b1;
        checks++;
        if (!prev_last) begin
          errors++;
          $display("FAIL done_timing: done=1 but previous cycle had no last handshake");
        end
      end
      prev_last = m_tvalid && m_tready && m_tlast;
      if (m_tvalid && m_tready) begin
        checks++;
        nbytes++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got d=%02h l=%0b, want none", m_tdata, m_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== e) begin
            errors++;
            $display("FAIL stream_byte: got l=%0b d=%02h, want l=%0b d=%02h",
                     m_tlast, m_tdata, e[8], e[7:0]);
          end
        end
        if (abort_after > 0 && nbytes == abort_after) aborted = 1'b1;
      end
    end
    if (!got_done && !aborted) begin
      checks++; errors++;
      $display("FAIL timeout: got no done in %0d cycles, want done", max_cycles);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, m_tvalid, m_tlast, ram_ceb} !== 5'b0 || m_tdata !== 8'd0 ||
        ram_adb !== 11'd0 || ram_oce !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b v=%0b l=%0b ceb=%0b d=%02h adb=%03h oce=%0b, want all 0, oce=1",
               busy, done, m_tvalid, m_tlast, ram_ceb, m_tdata, ram_adb, ram_oce);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    mem[11'h010] = 8'h11; mem[11'h011] = 8'h22; mem[11'h012] = 8'h33; mem[11'h013] = 8'h44;
    start_frame(11'h010, 12'd4);
    expect_frame(11'h010, 4);
    collect(0, 50, 0, -1);
    checks++;
    if (exp_q.size() != 0 || first_cyc > 3 || first_cyc < 0 || last_cyc - first_cyc != 3 + EXTRA) begin
      errors++;
      $display("FAIL basic_timing: got left=%0d first=%0d span=%0d, want 0, <=3, %0d",
               exp_q.size(), first_cyc, last_cyc - first_cyc, 3 + EXTRA);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%0b busy=%0b, want 0 0", done, busy);
    end
  endtask

  task automatic test_wrap;
    logic [10:0] a;
    start_frame(11'h7FE, 12'd4);
    expect_frame(11'h7FE, 4);
    collect(0, 50, 0, -1);
    checks++;
    if (adb_log.size() != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_count: got reads=%0d left=%0d, want 4 0", adb_log.size(), exp_q.size());
    end
    for (int i = 0; i < adb_log.size() && i < 4; i++) begin
      a = 11'h7FE + 11'(i);
      checks++;
      if (adb_log[i] !== a) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got %03h, want %03h", i, adb_log[i], a);
      end
    end
  endtask

  task automatic test_stall;
    start_frame(11'h200, 12'd8);
    expect_frame(11'h200, 8);
    collect(1, 100, 0, -1);
    checks++;
    if (exp_q.size() != 0 || nbytes != 8 + EXTRA) begin
      errors++;
      $display("FAIL stall_count: got bytes=%0d left=%0d, want %0d 0", nbytes, exp_q.size(), 8 + EXTRA);
    end
    m_tready = 1'b1;
  endtask

  task automatic test_csum;
    mem[11'h400] = 8'hF0; mem[11'h401] = 8'h20; mem[11'h402] = 8'h05;
    start_frame(11'h400, 12'd3);
`ifdef TX_FRAME_CSUM_EN
    exp_q.push_back(9'h0F0); exp_q.push_back(9'h020); exp_q.push_back(9'h005); exp_q.push_back(9'h115);
`else
    exp_q.push_back(9'h0F0); exp_q.push_back(9'h020); exp_q.push_back(9'h105);
`endif
    collect(0, 50, 0, -1);
    checks++;
    if (exp_q.size() != 0 || nbytes != 3 + EXTRA) begin
      errors++;
      $display("FAIL csum_count: got bytes=%0d left=%0d, want %0d 0", nbytes, exp_q.size(), 3 + EXTRA);
    end
  endtask

  task automatic test_bad_len;
    logic [11:0] bad [0:1];
    bad[0] = 12'd0; bad[1] = 12'd2049;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1; start = 1'b1; start_addr = 11'h020; length = bad[k];
      @(posedge clk); #1; start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ram_ceb !== 1'b0) begin
          errors++;
          $display("FAIL bad_len_%0d: got busy=%0b ceb=%0b, want 0 0", bad[k], busy, ram_ceb);
        end
      end
    end
    // second start while a frame is in flight must be ignored
    start_frame(11'h100, 12'd6);
    expect_frame(11'h100, 6);
    collect(0, 60, 0, 2);
    checks++;
    if (exp_q.size() != 0 || nbytes != 6 + EXTRA || adb_log.size() != 6) begin
      errors++;
      $display("FAIL restart_ignored: got bytes=%0d reads=%0d left=%0d, want %0d 6 0",
               nbytes, adb_log.size(), exp_q.size(), 6 + EXTRA);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_latched: got busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_max_len;
    start_frame(11'h005, 12'd2048);
    expect_frame(11'h005, 2048);
    collect(0, 2300, 0, -1);
    checks++;
    if (exp_q.size() != 0 || nbytes != 2048 + EXTRA || last_cyc - first_cyc != 2047 + EXTRA) begin
      errors++;
      $display("FAIL max_len: got bytes=%0d span=%0d left=%0d, want %0d %0d 0",
               nbytes, last_cyc - first_cyc, exp_q.size(), 2048 + EXTRA, 2047 + EXTRA);
    end
  endtask

  task automatic test_reset_abort;
    start_frame(11'h050, 12'd10);
    expect_frame(11'h050, 10);
    collect(0, 100, 3, -1);
    checks++;
    if (aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_point: got aborted=%0b, want 1", aborted);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, m_tvalid, m_tlast, ram_ceb} !== 5'b0 || m_tdata !== 8'd0 || ram_adb !== 11'd0) begin
      errors++;
      $display("FAIL abort_reset: got busy=%0b done=%0b v=%0b l=%0b ceb=%0b d=%02h adb=%03h, want all 0",
               busy, done, m_tvalid, m_tlast, ram_ceb, m_tdata, ram_adb);
    end
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: got v=%0b busy=%0b, want 0 0", m_tvalid, busy);
      end
    end
    start_frame(11'h050, 12'd10);
    expect_frame(11'h050, 10);
    collect(0, 100, 0, -1);
    checks++;
    if (exp_q.size() != 0 || nbytes != 10 + EXTRA) begin
      errors++;
      $display("FAIL fresh_frame: got bytes=%0d left=%0d, want %0d 0", nbytes, exp_q.size(), 10 + EXTRA);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_csum();
    test_bad_len();
    test_max_len();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tx_frame_reader.md
TX_FRAME_READER -- requirements
Module: tx_frame_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning buffer address width (2048 x 8 sample buffer).
REQ-002 SHALL have parameter LEN_W, default 12, meaning frame length width (1..2048 bytes).
REQ-003 SHALL have port clk, input, 1, meaning the single clock for all logic, also driving the buffer read port.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning one-cycle frame request, sampled only in IDLE.
REQ-006 SHALL have port start_addr, input, ADDR_W, meaning first buffer address of the frame.
REQ-007 SHALL have port length, input, LEN_W, meaning payload byte count.
REQ-008 SHALL have port busy, output, 1, meaning high from accepted start until done.
REQ-009 SHALL have port done, output, 1, meaning one-cycle frame-complete pulse.
REQ-010 SHALL have port ram_adb, output, ADDR_W, meaning buffer read address.
REQ-011 SHALL have port ram_ceb, output, 1, meaning buffer read clock enable.
REQ-012 SHALL have port ram_oce, output, 1, meaning buffer output enable, tied high.
REQ-013 SHALL have port ram_dout, input, 8, meaning buffer read data.
REQ-014 SHALL have ports m_tdata (output, 8), m_tvalid (output, 1), m_tready (input, 1), m_tlast (output, 1), meaning the byte stream to the TX serializer.

Function
REQ-015 SHALL treat the buffer as bypass-mode: data for the address presented with ram_ceb=1 at edge N is valid on ram_dout after edge N+1.
REQ-016 SHALL use states IDLE, READ, DRAIN, CSUM, DONE.
REQ-017 SHALL move IDLE->READ on start=1 with length in 1..2048; start with length=0 or length>2048 SHALL be ignored.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL assert ram_ceb in READ only when the 2-entry skid FIFO has a free slot, counting the in-flight read.
REQ-020 SHALL increment ram_adb per issued read, wrapping 2047->0.
REQ-021 SHALL move READ->DRAIN after issuing the last read, DRAIN->CSUM (checksum enabled) or DONE once the last payload byte is handshaken.
REQ-022 SHALL transfer a byte only when m_tvalid=1 and m_tready=1; m_tdata/m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-023 SHALL assert m_tlast on the final byte of the frame (last payload byte, or checksum byte when enabled).
REQ-024 SHALL sustain one byte per cycle with m_tready held high; first byte m_tvalid no later than 3 cycles after start.
REQ-025 SHALL pulse done for one cycle in DONE, then return to IDLE; busy SHALL fall with it.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state IDLE, busy=0, done=0, m_tvalid=0, m_tlast=0, m_tdata=0, ram_ceb=0, ram_adb=0, FIFO empty, checksum=0.
REQ-027 SHALL abort any frame in progress on reset with no further bytes emitted after release.

Configuration
REQ-028 SHALL compile the checksum byte only when TX_FRAME_CSUM_EN is defined.
REQ-029 With TX_FRAME_CSUM_EN: after the payload, one extra byte equal to the mod-256 sum of all payload bytes SHALL be sent in CSUM, carrying m_tlast; accumulator cleared on accepted start.
REQ-030 Without TX_FRAME_CSUM_EN: CSUM state and accumulator SHALL be absent; DRAIN->DONE directly; m_tlast on last payload byte.

Structure
REQ-031 SHALL take ADDR_W, LEN_W, MAX_LEN (2048) and the state enumeration from shared package tx_pkg.
REQ-032 SHALL instantiate one sub-module tx_skid_fifo (2-entry, 8-bit data + last flag) between buffer and stream.

Verification
REQ-033 start_addr=0x010, length=4, data 0x11,0x22,0x33,0x44, m_tready=1 -> four bytes in order, m_tlast on 0x44, done 1 cycle later.
REQ-034 start_addr=0x7FE, length=4 -> ram_adb sequence 0x7FE,0x7FF,0x000,0x001.
REQ-035 length=8, m_tready toggling 1/0 every cycle -> all 8 bytes delivered once, in order, data stable while stalled.
REQ-036 TX_FRAME_CSUM_EN, bytes 0xF0,0x20,0x05 -> stream 0xF0,0x20,0x05,0x15, m_tlast on 0x15 only.
REQ-037 length=0 or 2049 -> busy stays 0, no ram_ceb; second start mid-frame -> ignored.
REQ-038 rst_n low after 3 of 10 bytes -> all outputs zero immediately; new start after release sends a full fresh frame.
